instr_feeder: RTL and testbench

//  Upstream stage of processador_multiciclo: buffers 16-bit instruction/immediate words in a FIFO
//  and drives the processor's DIN and Run, issuing one instruction at a time and waiting for Done.

---
 rtl/instr_feeder_pkg.sv | 24 ++
 rtl/instr_feeder_if.sv | 31 +++
 rtl/instr_feeder_fifo.sv | 70 +++++++
 rtl/instr_feeder.sv | 171 +++++++++++++++++
 tb/tb_instr_feeder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_feeder_pkg.sv
// Shared definitions for the instruction feeder: processor opcodes, word width,
// FSM state encodings and a decode helper for the two-word mvi instruction.
package instr_feeder_pkg;

    localparam int DIN_W = 16;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_IMM   = 2'b10,
        ST_WAIT  = 2'b11
    } feeder_state_e;

    // mvi carries its immediate in the following word, so it needs two FIFO entries.
    function automatic logic is_mvi(input logic [DIN_W-1:0] word);
        return (word[8:6] == OP_MVI);
    endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// Bus between host/processor and the instruction feeder: host push port plus the
// processor DIN/Run/Done handshake. The feeder uses the master modport.
interface instr_feeder_if;
    import instr_feeder_pkg::*;

    logic             wr_en;
    logic [DIN_W-1:0] wr_data;
    logic             full;
    logic [DIN_W-1:0] DIN;
    logic             Run;
    logic             Done;

    modport master (
        input  wr_en,
        input  wr_data,
        input  Done,
        output full,
        output DIN,
        output Run
    );

    modport slave (
        output wr_en,
        output wr_data,
        output Done,
        input  full,
        input  DIN,
        input  Run
    );

endinterface

// File: rtl/instr_feeder_fifo.sv
// Show-ahead FIFO holding program words. A push is accepted only when not full
// (even if a pop happens in the same cycle); a rejected push sets the sticky ovf flag.
module instr_feeder_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          ovf_r;
    logic          push_s;
    logic          pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});
    assign push_s = wr_en && !full;
    assign pop_s  = pop && !empty;
    assign head   = mem_r[rd_ptr_r];
    assign count  = count_r;
    assign ovf    = ovf_r;

    // Storage array: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (wr_en && full) begin
                ovf_r <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder for processador_multiciclo: buffers a program in a FIFO and
// issues one instruction at a time on DIN/Run, waiting for Done between them.
// Optional feature: define FEEDER_TIMEOUT_EN to enable the WAIT_DONE watchdog
// (TIMEOUT_CYCLES); without it timeout is tied low and WAIT_DONE waits forever.
module instr_feeder
    import instr_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = DIN_W
`ifdef FEEDER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    instr_feeder_if.master       bus,
    input  logic                 start,
    output logic                 empty,
    output logic                 busy,
    output logic                 ovf,
    output logic [7:0]           issued,
    output logic                 timeout
);

    localparam int CW = $clog2(DEPTH) + 1;

    feeder_state_e state_r, state_n;
    logic          armed_r, armed_n;
    logic [DW-1:0] din_r, din_n;
    logic          run_r, run_n;
    logic [7:0]    issued_r, issued_n;
    logic          pop_s;
    logic          go_s;
    logic [DW-1:0] head_s;
    logic [CW-1:0] count_s;
    logic          empty_s;

    instr_feeder_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .CW    (CW)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (Resetn),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .pop     (pop_s),
        .head    (head_s),
        .count   (count_s),
        .full    (bus.full),
        .empty   (empty_s),
        .ovf     (ovf)
    );

    // An mvi is only issued once its immediate is already in the FIFO.
    assign go_s = armed_r &&
                  (((count_s >= CW'(1)) && !is_mvi(head_s)) || (count_s >= CW'(2)));

`ifdef FEEDER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_r, wd_n;
    logic          timeout_r, timeout_n;
    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    assign bus.DIN = din_r;
    assign bus.Run = run_r;
    assign empty   = empty_s;
    assign busy    = armed_r || (state_r != ST_IDLE);
    assign issued  = issued_r;

    // Next-state and next-output logic for the issue sequencer.
    always_comb begin
        state_n  = state_r;
        armed_n  = armed_r;
        din_n    = din_r;
        run_n    = 1'b0;
        issued_n = issued_r;
        pop_s    = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
        wd_n      = {WW{1'b0}};
        timeout_n = timeout_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (armed_r) begin
                    if (go_s) begin
                        state_n  = ST_ISSUE;
                        din_n    = head_s;
                        run_n    = 1'b1;
                        pop_s    = 1'b1;
                        issued_n = issued_r + 8'd1;
                    end else if (empty_s) begin
                        armed_n = 1'b0;
                    end else begin
                        armed_n = armed_r;
                    end
                end else if (start) begin
                    armed_n = 1'b1;
                end else begin
                    armed_n = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (is_mvi(din_r)) begin
                    din_n   = head_s;
                    pop_s   = 1'b1;
                    state_n = ST_IMM;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_IMM: begin
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.Done) begin
                    state_n = ST_IDLE;
                end else begin
`ifdef FEEDER_TIMEOUT_EN
                    if (wd_r == WW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_n = 1'b1;
                        armed_n   = 1'b0;
                        state_n   = ST_IDLE;
                    end else begin
                        wd_n = wd_r + WW'(1);
                    end
`else
                    state_n = ST_WAIT;
`endif
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, output and counter registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r  <= ST_IDLE;
            armed_r  <= 1'b0;
            din_r    <= {DW{1'b0}};
            run_r    <= 1'b0;
            issued_r <= 8'd0;
        end else begin
            state_r  <= state_n;
            armed_r  <= armed_n;
            din_r    <= din_n;
            run_r    <= run_n;
            issued_r <= issued_n;
        end
    end

`ifdef FEEDER_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wd_r      <= {WW{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            wd_r      <= wd_n;
            timeout_r <= timeout_n;
        end
    end
`endif

endmodule

// File: tb/tb_instr_feeder.sv
// Directed self-checking bench for instr_feeder.
module tb_instr_feeder;

    logic       Clock;
    logic       Resetn;
    logic       start;
    logic       empty;
    logic       busy;
    logic       ovf;
    logic [7:0] issued;
    logic       timeout;
    int         n_cmp;
    int         n_bad;
    logic       found;

    instr_feeder_if bus ();

    instr_feeder #(
        .DEPTH (16),
        .DW    (16)
`ifdef FEEDER_TIMEOUT_EN
        , .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .bus     (bus),
        .start   (start),
        .empty   (empty),
        .busy    (busy),
        .ovf     (ovf),
        .issued  (issued),
        .timeout (timeout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        bus.wr_en   = 1'b1;
        bus.wr_data = w;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        Resetn      = 1'b0;
        start       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 16'h0000;
        bus.Done    = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_din",     32'(bus.DIN),  32'h0);
        chk("rst_run",     32'(bus.Run),  32'h0);
        chk("rst_full",    32'(bus.full), 32'h0);
        chk("rst_empty",   32'(empty),    32'h1);
        chk("rst_busy",    32'(busy),     32'h0);
        chk("rst_ovf",     32'(ovf),      32'h0);
        chk("rst_issued",  32'(issued),   32'h0);
        chk("rst_timeout", 32'(timeout),  32'h0);
        Resetn = 1'b1;
        tick();

        // 1: single mv, Done three cycles after Run
        push(16'h0008);
        chk("t1_empty", 32'(empty), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_armed_busy", 32'(busy),    32'h1);
        chk("t1_run_early",  32'(bus.Run), 32'h0);
        tick();
        chk("t1_run",    32'(bus.Run), 32'h1);
        chk("t1_din",    32'(bus.DIN), 32'h0008);
        chk("t1_issued", 32'(issued),  32'h1);
        chk("t1_popped", 32'(empty),   32'h1);
        tick();
        chk("t1_run_low", 32'(bus.Run), 32'h0);
        chk("t1_din_hold", 32'(bus.DIN), 32'h0008);
        tick();
        chk("t1_run_low2", 32'(bus.Run), 32'h0);
        chk("t1_timeout0", 32'(timeout), 32'h0);
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        chk("t1_busy_armed", 32'(busy), 32'h1);
        tick();
        chk("t1_busy_fall", 32'(busy),    32'h0);
        chk("t1_no_rerun",  32'(bus.Run), 32'h0);
        chk("t1_issued_end", 32'(issued), 32'h1);

        // 2: mvi with immediate already queued
        push(16'h0040);
        push(16'h00A5);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t2_run",    32'(bus.Run), 32'h1);
        chk("t2_din",    32'(bus.DIN), 32'h0040);
        chk("t2_issued", 32'(issued),  32'h2);
        tick();
        chk("t2_imm_run", 32'(bus.Run), 32'h0);
        chk("t2_imm_din", 32'(bus.DIN), 32'h00A5);
        chk("t2_empty",   32'(empty),   32'h1);
        tick();
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        tick();
        chk("t2_busy_fall", 32'(busy), 32'h0);

        // 3: mvi without its immediate waits, then issues once it arrives
        push(16'h0040);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t3_norun1", 32'(bus.Run), 32'h0);
        tick();
        chk("t3_norun2", 32'(bus.Run), 32'h0);
        chk("t3_busy",   32'(busy),    32'h1);
        push(16'h1234);
        chk("t3_norun3", 32'(bus.Run), 32'h0);
        tick();
        chk("t3_run",    32'(bus.Run), 32'h1);
        chk("t3_din",    32'(bus.DIN), 32'h0040);
        chk("t3_issued", 32'(issued),  32'h3);
        tick();
        chk("t3_imm_run", 32'(bus.Run), 32'h0);
        chk("t3_imm_din", 32'(bus.DIN), 32'h1234);
        tick();
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        tick();
        chk("t3_busy_fall", 32'(busy), 32'h0);

        // 4: fill to full, overflow, push rejected at full during a pop, drain
        for (int k = 0; k < 16; k++) begin
            push(16'(k));
        end
        chk("t4_full",     32'(bus.full), 32'h1);
        chk("t4_ovf_pre",  32'(ovf),      32'h0);
        push(16'h0011);
        chk("t4_ovf",      32'(ovf),      32'h1);
        chk("t4_full2",    32'(bus.full), 32'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 16'h0033;
        tick();
        bus.wr_en = 1'b0;
        bus.Done  = 1'b1;
        chk("t4_run0",     32'(bus.Run),  32'h1);
        chk("t4_din0",     32'(bus.DIN),  32'h0000);
        chk("t4_not_full", 32'(bus.full), 32'h0);
        for (int k = 1; k < 16; k++) begin
            found = 1'b0;
            for (int t = 0; t < 8 && !found; t++) begin
                tick();
                if (bus.Run === 1'b1) begin
                    found = 1'b1;
                end
            end
            chk("t4_run_seen", 32'(found),   32'h1);
            chk("t4_din_seq",  32'(bus.DIN), 32'(k));
        end
        for (int t = 0; t < 4; t++) begin
            tick();
        end
        bus.Done = 1'b0;
        chk("t4_drained",  32'(empty),    32'h1);
        chk("t4_issued",   32'(issued),   32'd19);
        chk("t4_busy",     32'(busy),     32'h0);
        chk("t4_run_idle", 32'(bus.Run),  32'h0);
        chk("t4_ovf_stk",  32'(ovf),      32'h1);

        // 5: asynchronous reset during WAIT_DONE
        push(16'h0008);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t5_wait_din", 32'(bus.DIN), 32'h0008);
        #2;
        Resetn = 1'b0;
        #1;
        chk("t5_run",    32'(bus.Run), 32'h0);
        chk("t5_din",    32'(bus.DIN), 32'h0);
        chk("t5_empty",  32'(empty),   32'h1);
        chk("t5_issued", 32'(issued),  32'h0);
        chk("t5_ovf",    32'(ovf),     32'h0);
        chk("t5_busy",   32'(busy),    32'h0);
        bus.Done = 1'b1;
        tick();
        Resetn = 1'b1;
        tick();
        tick();
        bus.Done = 1'b0;
        chk("t5_done_ign_run",  32'(bus.Run), 32'h0);
        chk("t5_done_ign_busy", 32'(busy),    32'h0);
        chk("t5_done_ign_iss",  32'(issued),  32'h0);

`ifdef FEEDER_TIMEOUT_EN
        // 6: watchdog fires after 8 cycles without Done
        push(16'h0008);
        push(16'h0010);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t6_run", 32'(bus.Run), 32'h1);
        tick();
        for (int t = 0; t < 7; t++) begin
            tick();
        end
        chk("t6_not_yet", 32'(timeout), 32'h0);
        tick();
        chk("t6_timeout", 32'(timeout), 32'h1);
        chk("t6_idle",    32'(busy),    32'h0);
        chk("t6_kept",    32'(empty),   32'h0);
        tick();
        chk("t6_no_issue", 32'(bus.Run), 32'h0);
        chk("t6_sticky",   32'(timeout), 32'h1);
`else
        chk("t6_tied_low", 32'(timeout), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
